// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared defines for the RV32M multiply/divide unit
package mul_div_unit_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // RV32M funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mulDivOp_t;

    // rs1 is interpreted as two's complement
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as two's complement
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply / restoring divide unit
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   result_q;

    // Request decode: magnitudes, result sign, and the cases that skip iteration
    logic            sign_a, sign_b, is_div, rem_sel;
    logic            div_zero, div_ovf, bypass, neg_in;
    logic [XLEN-1:0] mag_a, mag_b, bypass_result;

    assign sign_a   = op_signed_a(op) & operandA[XLEN-1];
    assign sign_b   = op_signed_b(op) & operandB[XLEN-1];
    assign mag_a    = sign_a ? -operandA : operandA;
    assign mag_b    = sign_b ? -operandB : operandB;
    assign is_div   = op[2];
    assign rem_sel  = op[1];
    assign div_zero = is_div && (operandB == '0);
    assign div_ovf  = is_div && !op[0]
                      && (operandA == {1'b1, {(XLEN-1){1'b0}}})
                      && (operandB == '1);
    assign bypass   = div_zero || div_ovf;
    assign neg_in   = (is_div && rem_sel) ? sign_a : (sign_a ^ sign_b);

    assign bypass_result = div_zero ? (rem_sel ? operandA : '1)
                                    : (rem_sel ? '0 : operandA);

    // One iteration of the shared shift datapath.
    // Multiply: acc = {partial product, remaining multiplier}, add then shift right.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    logic [XLEN:0]     mul_addend, mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next;

    assign mul_addend = acc[0] ? {1'b0, opb_q} : '0;
    assign mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + mul_addend;
    assign mul_next   = {mul_sum, acc[XLEN-1:1]};

    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, opb_q};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};

    assign acc_next = op_q[2] ? div_next : mul_next;

    // Sign fix-up applied to the last iteration's value as the unit enters DONE
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_mag, rem_mag, quot_fix, rem_fix, final_result;

    assign prod_fix = neg_q ? -acc_next : acc_next;
    assign quot_mag = acc_next[XLEN-1:0];
    assign rem_mag  = acc_next[2*XLEN-1:XLEN];
    assign quot_fix = neg_q ? -quot_mag : quot_mag;
    assign rem_fix  = neg_q ? -rem_mag : rem_mag;

    // Select the architectural result for the captured op
    always_comb begin
        final_result = prod_fix[XLEN-1:0];
        case (op_q)
            OP_MUL:                       final_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = quot_fix;
            default:                      final_result = rem_fix;
        endcase
    end

    // Control FSM and datapath registers; reset beats flush beats handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc      <= '0;
            count    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        op_q  <= op;
                        neg_q <= neg_in;
                        opb_q <= mag_b;
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        count <= '0;
                        if (bypass) begin
                            result_q <= bypass_result;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == CW'(XLEN - 1)) begin
                        result_q <= final_result;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);
    assign busy     = (state != IDLE);
    assign result   = result_q;

endmodule
